dht11_emulador: RTL and testbench

- Synthesizable DHT11 sensor emulator: the responder end of the single-wire protocol that the DHT11 measurement interface initiates.
- Watches the open-drain bus for the host start pulse, then answers with the standard response and a 40-bit frame built from programmable humidity and temperature values.
- Used for hardware-in-the-loop bring-up of the measurement path on the board, and as a bus-accurate model in system benches.

---
 rtl/dht11_emulador_pkg.sv | 34 +++
 rtl/dht11_emul_temporizador.sv | 24 ++
 rtl/dht11_emulador.sv | 151 +++++++++++++++
 tb/tb_dht11_emulador.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_emulador_pkg.sv
// Shared DHT11 definitions: emulator FSM states, frame size and
// protocol timing defaults in microseconds.
package dht11_emulador_pkg;

  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    MEDE_START    = 4'd1,
    AGUARDA_SOLTA = 4'd2,
    ESPERA        = 4'd3,
    RESP_BAIXO    = 4'd4,
    RESP_ALTO     = 4'd5,
    BIT_BAIXO     = 4'd6,
    BIT_ALTO      = 4'd7,
    FIM_BAIXO     = 4'd8
  } estado_t;

  localparam int FRAME_BITS = 40;

  localparam int DHT_CICLOS_US      = 50;
  localparam int DHT_T_START_MIN_US = 18000;
  localparam int DHT_T_ESPERA_US    = 30;
  localparam int DHT_T_RESP_US      = 80;
  localparam int DHT_T_BIT_BAIXO_US = 50;
  localparam int DHT_T_BIT0_US      = 27;
  localparam int DHT_T_BIT1_US      = 70;

  function automatic logic [7:0] checksum(
    input logic [15:0] u,
    input logic [15:0] t
  );
    return u[15:8] + u[7:0] + t[15:8] + t[7:0];
  endfunction

endpackage

// File: rtl/dht11_emul_temporizador.sv
// Phase timer: counts from zero after load and flags the last
// cycle of a phase lasting 'termo' cycles, then holds.
module dht11_emul_temporizador #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] termo,
  output logic         fim
);

  logic [W-1:0] cnt;

  assign fim = (cnt == termo - 1'b1);

  always_ff @(posedge clock) begin
    if (reset || load)
      cnt <= '0;
    else if (!fim)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dht11_emulador.sv
// DHT11 sensor emulator: detects the host start pulse and answers
// with the response preamble and a 40-bit humidity/temperature frame.
module dht11_emulador
  import dht11_emulador_pkg::*;
#(
  parameter int CICLOS_US      = DHT_CICLOS_US,
  parameter int T_START_MIN_US = DHT_T_START_MIN_US,
  parameter int T_ESPERA_US    = DHT_T_ESPERA_US,
  parameter int T_RESP_US      = DHT_T_RESP_US,
  parameter int T_BIT_BAIXO_US = DHT_T_BIT_BAIXO_US,
  parameter int T_BIT0_US      = DHT_T_BIT0_US,
  parameter int T_BIT1_US      = DHT_T_BIT1_US
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire         dht_bus,
  input  logic        habilita,
  input  logic [15:0] umidade,
  input  logic [15:0] temperatura,
  input  logic        corrompe_checksum,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam int CW = $clog2(CICLOS_US * T_START_MIN_US + 1);

  localparam logic [CW-1:0] N_START = CW'(CICLOS_US * T_START_MIN_US);
  localparam logic [CW-1:0] N_ESP   = CW'(CICLOS_US * T_ESPERA_US);
  localparam logic [CW-1:0] N_RESP  = CW'(CICLOS_US * T_RESP_US);
  localparam logic [CW-1:0] N_BB    = CW'(CICLOS_US * T_BIT_BAIXO_US);
  localparam logic [CW-1:0] N_B0    = CW'(CICLOS_US * T_BIT0_US);
  localparam logic [CW-1:0] N_B1    = CW'(CICLOS_US * T_BIT1_US);
  localparam logic [5:0]    ULTIMO  = 6'(FRAME_BITS - 1);

  estado_t estado, prox;

  logic                  sinc1, sinc2;
  logic                  drive_en;
  logic [FRAME_BITS-1:0] dado;
  logic [5:0]            indice;
  logic [CW-1:0]         termo;
  logic                  fim, load;
  logic                  captura, avanca, fecha;
  logic [7:0]            soma;

  assign dht_bus   = drive_en ? 1'b0 : 1'bz;
  assign db_estado = estado;
  assign load      = (prox != estado);
  assign soma      = checksum(umidade, temperatura)
                   ^ {8{corrompe_checksum}};

  dht11_emul_temporizador #(.W(CW)) u_temp (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .termo (termo),
    .fim   (fim)
  );

  always_comb begin
    prox    = estado;
    termo   = CW'(1);
    captura = 1'b0;
    avanca  = 1'b0;
    fecha   = 1'b0;
    unique case (estado)
      OCIOSO:
        if (!sinc2 && habilita) prox = MEDE_START;
      MEDE_START: begin
        termo = N_START;
        // Reaching the minimum low time wins over a same-cycle release
        if (fim)        prox = AGUARDA_SOLTA;
        else if (sinc2) prox = OCIOSO;
      end
      AGUARDA_SOLTA:
        if (sinc2) begin
          prox    = ESPERA;
          captura = 1'b1;
        end
      ESPERA: begin
        termo = N_ESP;
        if (fim) prox = RESP_BAIXO;
      end
      RESP_BAIXO: begin
        termo = N_RESP;
        if (fim) prox = RESP_ALTO;
      end
      RESP_ALTO: begin
        termo = N_RESP;
        if (fim) prox = BIT_BAIXO;
      end
      BIT_BAIXO: begin
        termo = N_BB;
        if (fim) prox = BIT_ALTO;
      end
      BIT_ALTO: begin
        termo = dado[FRAME_BITS-1] ? N_B1 : N_B0;
        if (fim) begin
          avanca = 1'b1;
          prox   = (indice == ULTIMO) ? FIM_BAIXO : BIT_BAIXO;
        end
      end
      FIM_BAIXO: begin
        termo = N_BB;
        if (fim) begin
          prox  = OCIOSO;
          fecha = 1'b1;
        end
      end
      default: prox = OCIOSO;
    endcase
  end

  // Drive is registered from the next state so it tracks the
  // state register edge for edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      sinc1    <= 1'b1;
      sinc2    <= 1'b1;
      drive_en <= 1'b0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      estado   <= prox;
      sinc1    <= dht_bus;
      sinc2    <= sinc1;
      drive_en <= (prox == RESP_BAIXO) ||
                  (prox == BIT_BAIXO)  ||
                  (prox == FIM_BAIXO);
      pronto   <= fecha;
      if (captura)    ocupado <= 1'b1;
      else if (fecha) ocupado <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dado   <= '0;
      indice <= '0;
    end else if (captura) begin
      dado   <= {umidade, temperatura, soma};
      indice <= '0;
    end else if (avanca) begin
      dado   <= {dado[FRAME_BITS-2:0], 1'b0};
      indice <= indice + 1'b1;
    end
  end

endmodule

// File: tb/tb_dht11_emulador.sv
// Bench for dht11_emulador: host start pulses, bus waveform capture
// and frame decode against a waveform model built from the timings.
module tb_dht11_emulador;
  import dht11_emulador_pkg::*;

  localparam int C  = 1;
  localparam int ST = 300;
  localparam int E  = DHT_T_ESPERA_US * C;
  localparam int R  = DHT_T_RESP_US * C;
  localparam int BL = DHT_T_BIT_BAIXO_US * C;
  localparam int H0 = DHT_T_BIT0_US * C;
  localparam int H1 = DHT_T_BIT1_US * C;
  localparam int LIM = 4 * ST;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        habilita = 1'b1;
  logic        corrompe = 1'b0;
  logic        host_low = 1'b0;
  logic [15:0] umidade = '0;
  logic [15:0] temperatura = '0;
  wire         dht_bus;
  logic        ocupado, pronto;
  logic [3:0]  db_estado;

  int errors = 0;
  int checks = 0;
  int npronto = 0;

  assign dht_bus = host_low ? 1'b0 : 1'bz;
  pullup (dht_bus);

  always #5 clock = ~clock;

  always @(negedge clock)
    if (pronto === 1'b1) npronto++;

  dht11_emulador #(
    .CICLOS_US      (C),
    .T_START_MIN_US (ST)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .dht_bus           (dht_bus),
    .habilita          (habilita),
    .umidade           (umidade),
    .temperatura       (temperatura),
    .corrompe_checksum (corrompe),
    .ocupado           (ocupado),
    .pronto            (pronto),
    .db_estado         (db_estado)
  );

  task automatic check(input string nome,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  function automatic logic [39:0] model_frame(
    input logic [15:0] u, input logic [15:0] t, input logic c);
    int s;
    s = (int'(u[15:8]) + int'(u[7:0]) +
         int'(t[15:8]) + int'(t[7:0])) % 256;
    if (c) s = 255 - s;
    return {u, t, 8'(s)};
  endfunction

  task automatic run_len(input logic lvl, input int limit,
                         output int n);
    n = 0;
    while (dht_bus === lvl && n < limit) begin
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic frame(input logic [15:0] u,
                       input logic [15:0] t,
                       input logic corr,
                       input int lo,
                       input bit resp,
                       input int abort_run,
                       input int change_run,
                       input logic [15:0] t_new,
                       output logic [39:0] got);
    logic [39:0] exp_f;
    int q[$];
    int n, gap, bad, first_bad, np0;
    got = '0;
    umidade = u;
    temperatura = t;
    corrompe = corr;
    exp_f = model_frame(u, t, corr);
    np0 = npronto;
    @(negedge clock);
    host_low = 1'b1;
    repeat (lo) @(negedge clock);
    host_low = 1'b0;
    @(posedge clock); #1;
    if (!resp) begin
      run_len(1'b1, E + 2 * R, n);
      check("silent bus", n, E + 2 * R);
      check("idle ocupado", ocupado, 1'b0);
      check("idle state", db_estado, 4'd0);
      check("no pronto", npronto - np0, 0);
      return;
    end
    // An exactly-minimum pulse is released while still being
    // qualified, so the release is seen one cycle later.
    gap = E + 2 + ((lo == ST) ? 1 : 0);
    run_len(1'b1, LIM, n);
    check("release gap", n, gap);
    check("ocupado in frame", ocupado, 1'b1);
    q = {};
    q.push_back(R);
    q.push_back(R);
    for (int k = 0; k < 40; k++) begin
      q.push_back(BL);
      q.push_back(exp_f[39-k] ? H1 : H0);
    end
    q.push_back(BL);
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_run) begin
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("bus after reset", dht_bus, 1'b1);
        check("state after reset", db_estado, 4'd0);
        check("ocupado after reset", ocupado, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        return;
      end
      if (i == change_run) begin
        temperatura = t_new;
        habilita = 1'b0;
      end
      if (change_run >= 0 && i == change_run + 40)
        habilita = 1'b1;
      run_len((i % 2 == 0) ? 1'b0 : 1'b1, LIM, n);
      if (i >= 3 && i % 2 == 1)
        got = {got[38:0], (n > (H0 + H1) / 2) ? 1'b1 : 1'b0};
      if (n != q[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    check($sformatf("waveform runs (first bad %0d)", first_bad),
          bad, 0);
    check("frame bits", got, exp_f);
    check("pronto at end", pronto, 1'b1);
    check("ocupado cleared", ocupado, 1'b0);
    @(posedge clock); #1;
    check("pronto one pulse", npronto - np0, 1);
    check("pronto low after", pronto, 1'b0);
  endtask

  typedef struct {
    logic [15:0] u;
    logic [15:0] t;
    logic        corr;
    logic        hab;
    int          lo;
    bit          resp;
    logic [7:0]  sum;
  } vec_t;

  vec_t tab[6];

  initial begin
    logic [39:0] got;
    tab[0] = '{16'h3C00, 16'h1905, 1'b0, 1'b1, ST,     1'b1, 8'h5A};
    tab[1] = '{16'h3C00, 16'h1905, 1'b0, 1'b1, ST / 2, 1'b0, 8'h00};
    tab[2] = '{16'h3C00, 16'h1905, 1'b0, 1'b1, ST - 1, 1'b0, 8'h00};
    tab[3] = '{16'h3C00, 16'h1905, 1'b1, 1'b1, ST + 20, 1'b1, 8'hA5};
    tab[4] = '{16'h3C00, 16'h1905, 1'b0, 1'b0, 2 * ST, 1'b0, 8'h00};
    tab[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, ST + 1, 1'b1, 8'hFC};

    repeat (3) @(negedge clock);
    @(posedge clock); #1;
    check("reset state", db_estado, 4'd0);
    check("reset ocupado", ocupado, 1'b0);
    check("reset pronto", pronto, 1'b0);
    check("reset bus", dht_bus, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    foreach (tab[i]) begin
      habilita = tab[i].hab;
      frame(tab[i].u, tab[i].t, tab[i].corr, tab[i].lo,
            tab[i].resp, -1, -1, 16'h0, got);
      if (tab[i].resp)
        check($sformatf("checksum vec %0d", i), got[7:0], tab[i].sum);
      habilita = 1'b1;
      repeat (10) @(negedge clock);
    end

    for (int r = 0; r < 3; r++) begin
      frame(16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)),
            ST + int'($urandom_range(0, 30)),
            1'b1, -1, -1, 16'h0, got);
      repeat (5) @(negedge clock);
    end

    frame(16'h3C00, 16'h1905, 1'b0, ST + 10, 1'b1,
          2 + 2 * 12, -1, 16'h0, got);
    repeat (5) @(negedge clock);
    frame(16'h3C00, 16'h1905, 1'b0, ST + 10, 1'b1,
          -1, -1, 16'h0, got);
    check("frame after reset", got, 40'h3C0019055A);

    frame(16'h3C00, 16'h1905, 1'b0, ST + 5, 1'b1,
          -1, 2 + 2 * 5, 16'h2000, got);
    check("data change ignored", got, 40'h3C0019055A);
    frame(16'h3C00, 16'h2000, 1'b0, ST + 5, 1'b1,
          -1, -1, 16'h0, got);
    check("back to back frame", got, 40'h3C0020005C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
